mem_arbiter: RTL and testbench

Two-port memory arbiter and sequencer sharing one external memory bus between instruction fetch (IF) and the memory-access stage (ME). It turns combinational-style stage requests into a registered req/ack bus transaction and raises per-port stall requests until data is ready. Each port has a one-entry tagged holding register, so a stalled pipeline re-presenting the same request does not re-issue it. Data requests have priority over fetch. A watchdog aborts bus transactions that are never acknowledged.

---
 rtl/mem_arbiter_if.sv | 20 ++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// External memory bus: registered request fields from the arbiter, ack and read data back.
interface mem_arbiter_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory bus between fetch (IF) and data (ME) ports with tagged one-entry holding registers.
// ME wins over IF; a watchdog completes never-acknowledged transactions with data 0 and a sticky error.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_ce_i,
  input  logic [31:0]   if_addr_i,
  output logic [31:0]   if_data_o,
  output logic          if_stall_o,
  input  logic          me_ce_i,
  input  logic          me_we_i,
  input  logic [31:0]   me_addr_i,
  input  logic [3:0]    me_sel_i,
  input  logic [31:0]   me_wdata_i,
  output logic [31:0]   me_rdata_o,
  output logic          me_stall_o,
  output logic          err_o,
  mem_arbiter_if.master bus
);
  localparam int            CW       = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS_ME, BUS_IF} state_t;

  typedef struct packed {
    logic        we;
    logic [29:0] waddr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } me_tag_t;

  state_t      state_q, state_d;
  logic        if_vld_q, if_vld_d;
  logic [29:0] if_tag_q, if_tag_d;
  logic [31:0] if_data_q, if_data_d;
  logic        me_vld_q, me_vld_d;
  me_tag_t     me_tag_q, me_tag_d;
  logic [31:0] me_data_q, me_data_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  me_tag_t     me_req_tag;
  logic        if_hit, me_hit, expire, done;
  logic [31:0] cap_data;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^{if_addr_i[1:0], me_addr_i[1:0]};

  assign me_req_tag = '{we: me_we_i, waddr: me_addr_i[31:2], sel: me_sel_i, wdata: me_wdata_i};
  assign if_hit     = if_ce_i & if_vld_q & (if_tag_q == if_addr_i[31:2]);
  assign me_hit     = me_ce_i & me_vld_q & (me_tag_q == me_req_tag);
  assign if_stall_o = if_ce_i & ~if_hit;
  assign me_stall_o = me_ce_i & ~me_hit;

  // A real ack in the expiry cycle takes precedence and does not flag an error.
  assign expire   = (TIMEOUT != 0) && !bus.bus_ack_i && (cnt_q == TMO_LAST);
  assign done     = bus.bus_ack_i | expire;
  assign cap_data = (expire || bus_we_q) ? 32'h0 : bus.bus_rdata_i;

  always_comb begin
    state_d     = state_q;
    if_vld_d    = if_vld_q;
    if_tag_d    = if_tag_q;
    if_data_d   = if_data_q;
    me_vld_d    = me_vld_q;
    me_tag_d    = me_tag_q;
    me_data_d   = me_data_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (me_stall_o) begin
          state_d     = BUS_ME;
          bus_req_d   = 1'b1;
          bus_we_d    = me_we_i;
          bus_addr_d  = {me_addr_i[31:2], 2'b00};
          bus_sel_d   = me_sel_i;
          bus_wdata_d = me_wdata_i;
          cnt_d       = '0;
        end else if (if_stall_o) begin
          state_d     = BUS_IF;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = {if_addr_i[31:2], 2'b00};
          bus_sel_d   = 4'b1111;
          bus_wdata_d = 32'h0;
          cnt_d       = '0;
        end
      end
      BUS_ME, BUS_IF: begin
        if (done) begin
          if (state_q == BUS_ME) begin
            me_vld_d  = 1'b1;
            me_tag_d  = '{we: bus_we_q, waddr: bus_addr_q[31:2], sel: bus_sel_q, wdata: bus_wdata_q};
            me_data_d = cap_data;
            // A store makes any fetched copy of the same word stale.
            if (bus_we_q && (if_tag_q == bus_addr_q[31:2])) if_vld_d = 1'b0;
          end else begin
            if_vld_d  = 1'b1;
            if_tag_d  = bus_addr_q[31:2];
            if_data_d = cap_data;
          end
          err_d     = err_q | expire;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      if_vld_q    <= 1'b0;
      if_tag_q    <= '0;
      if_data_q   <= '0;
      me_vld_q    <= 1'b0;
      me_tag_q    <= '0;
      me_data_q   <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      if_vld_q    <= if_vld_d;
      if_tag_q    <= if_tag_d;
      if_data_q   <= if_data_d;
      me_vld_q    <= me_vld_d;
      me_tag_q    <= me_tag_d;
      me_data_q   <= me_data_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign if_data_o       = if_data_q;
  assign me_rdata_o      = me_data_q;
  assign err_o           = err_q;
  assign bus.bus_req_o   = bus_req_q;
  assign bus.bus_we_o    = bus_we_q;
  assign bus.bus_addr_o  = bus_addr_q;
  assign bus.bus_sel_o   = bus_sel_q;
  assign bus.bus_wdata_o = bus_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle, plus literal spot checks.
module tb_mem_arbiter;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_ce = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_data;
  logic        if_stall;
  logic        me_ce = 1'b0;
  logic        me_we = 1'b0;
  logic [31:0] me_addr = '0;
  logic [3:0]  me_sel = '0;
  logic [31:0] me_wdata = '0;
  logic [31:0] me_rdata;
  logic        me_stall;
  logic        err;

  mem_arbiter_if bus_if();

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_ce_i    (if_ce),
    .if_addr_i  (if_addr),
    .if_data_o  (if_data),
    .if_stall_o (if_stall),
    .me_ce_i    (me_ce),
    .me_we_i    (me_we),
    .me_addr_i  (me_addr),
    .me_sel_i   (me_sel),
    .me_wdata_i (me_wdata),
    .me_rdata_o (me_rdata),
    .me_stall_o (me_stall),
    .err_o      (err),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory responder: acks in the lat-th bus cycle of a transaction (lat=0 never acks).
  logic [31:0] mem [logic [31:0]];
  int   lat = 3;
  int   bcnt = 0;
  logic resp_ack = 1'b0;
  logic stray_ack = 1'b0;
  logic [31:0] rd_word;

  initial bus_if.bus_rdata_i = 32'hBAD0BAD0;
  always_comb bus_if.bus_ack_i = resp_ack | stray_ack;

  always @(posedge clk) begin
    #1;
    resp_ack = 1'b0;
    bus_if.bus_rdata_i = 32'hBAD0BAD0;
    if (bus_if.bus_req_o) begin
      bcnt++;
      if (lat != 0 && bcnt == lat) begin
        resp_ack = 1'b1;
        rd_word = mem.exists(bus_if.bus_addr_o) ? mem[bus_if.bus_addr_o] : 32'h0;
        if (bus_if.bus_we_o) begin
          for (int i = 0; i < 4; i++)
            if (bus_if.bus_sel_o[i]) rd_word[31-8*i -: 8] = bus_if.bus_wdata_o[31-8*i -: 8];
          mem[bus_if.bus_addr_o] = rd_word;
        end else begin
          bus_if.bus_rdata_i = rd_word;
        end
      end
    end else begin
      bcnt = 0;
    end
  end

  // Model: each port keeps the last completed transaction; at most one transaction is in flight.
  logic        m_if_v, m_me_v, m_busy, m_is_me, m_we, m_err, m_me_we;
  logic [29:0] m_if_tag, m_me_wa;
  logic [31:0] m_if_data, m_me_data, m_addr, m_wd, m_me_wd;
  logic [3:0]  m_sel, m_me_sel;
  int          m_age;

  function automatic logic m_if_hit();
    return if_ce && m_if_v && (m_if_tag == if_addr[31:2]);
  endfunction

  function automatic logic m_me_hit();
    return me_ce && m_me_v && (m_me_we == me_we) && (m_me_wa == me_addr[31:2]) &&
           (m_me_sel == me_sel) && (m_me_wd == me_wdata);
  endfunction

  always @(posedge clk) begin
    logic        ab;
    logic [31:0] d;
    if (rst) begin
      m_if_v = 0; m_me_v = 0; m_busy = 0; m_err = 0; m_age = 0;
      m_if_tag = 0; m_if_data = 0; m_me_data = 0;
      m_me_we = 0; m_me_wa = 0; m_me_sel = 0; m_me_wd = 0;
      m_is_me = 0; m_we = 0; m_addr = 0; m_sel = 0; m_wd = 0;
    end else if (m_busy) begin
      ab = !bus_if.bus_ack_i && (TMO != 0) && (m_age == TMO);
      if (bus_if.bus_ack_i || ab) begin
        d = (ab || m_we) ? 32'h0 : bus_if.bus_rdata_i;
        if (m_is_me) begin
          m_me_v = 1; m_me_we = m_we; m_me_wa = m_addr[31:2]; m_me_sel = m_sel; m_me_wd = m_wd;
          m_me_data = d;
          if (m_we && m_if_tag == m_addr[31:2]) m_if_v = 0;
        end else begin
          m_if_v = 1; m_if_tag = m_addr[31:2]; m_if_data = d;
        end
        if (ab) m_err = 1;
        m_busy = 0;
      end else begin
        m_age++;
      end
    end else if (me_ce && !m_me_hit()) begin
      m_busy = 1; m_is_me = 1; m_age = 1;
      m_we = me_we; m_addr = {me_addr[31:2], 2'b00}; m_sel = me_sel; m_wd = me_wdata;
    end else if (if_ce && !m_if_hit()) begin
      m_busy = 1; m_is_me = 0; m_age = 1;
      m_we = 0; m_addr = {if_addr[31:2], 2'b00}; m_sel = 4'hF; m_wd = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("if_stall", if_stall, if_ce & ~m_if_hit());
      chk("me_stall", me_stall, me_ce & ~m_me_hit());
      chk("if_data", if_data, m_if_data);
      chk("me_rdata", me_rdata, m_me_data);
      chk("err", err, m_err);
      chk("bus_req", bus_if.bus_req_o, m_busy);
      if (m_busy) begin
        chk("bus_addr", bus_if.bus_addr_o, m_addr);
        chk("bus_we", bus_if.bus_we_o, m_we);
        chk("bus_sel", bus_if.bus_sel_o, m_sel);
        chk("bus_wdata", bus_if.bus_wdata_o, m_wd);
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  // Count stalled cycles until both ports are satisfied; record the first bus request seen.
  task automatic settle(input string name, output int n_if, output int n_me, output int n_req,
                        output logic [31:0] a0, output logic [3:0] s0);
    logic got, fin;
    n_if = 0; n_me = 0; n_req = 0; a0 = 32'hFFFFFFFF; s0 = 4'h0; got = 0; fin = 0;
    for (int i = 0; i < 60 && !fin; i++) begin
      @(negedge clk);
      if (bus_if.bus_req_o) begin
        n_req++;
        if (!got) begin a0 = bus_if.bus_addr_o; s0 = bus_if.bus_sel_o; got = 1; end
      end
      if (!if_stall && !me_stall) fin = 1;
      else begin
        n_if += int'(if_stall);
        n_me += int'(me_stall);
      end
    end
    if (!fin) chk({name, "_settle_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timeout");
  end

  int n_if, n_me, n_req;
  logic [31:0] a0;
  logic [3:0]  s0;

  initial begin
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h000] = 32'h11111111;
    mem[32'h204] = 32'h22220204;
    mem[32'h208] = 32'hABCD0208;
    mem[32'h300] = 32'h77777777;
    mem[32'h400] = 32'h40404040;

    // Reset state, with a fetch pending so the stall formula is visible
    if_ce = 1; if_addr = 32'h100;
    @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("rst_bus_req", bus_if.bus_req_o, 0);
    chk("rst_bus_addr", bus_if.bus_addr_o, 0);
    chk("rst_bus_sel", bus_if.bus_sel_o, 0);
    chk("rst_bus_wdata", bus_if.bus_wdata_o, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_err", err, 0);
    chk("rst_if_stall", if_stall, 1);
    chk("rst_me_stall", me_stall, 0);

    // Single fetch miss, ack in the third bus cycle
    drive_edge(); rst = 0;
    settle("fetch", n_if, n_me, n_req, a0, s0);
    chk("fetch_stall_cycles", n_if, 4);
    chk("fetch_addr", a0, 32'h100);
    chk("fetch_sel", s0, 4'hF);
    chk("fetch_data", if_data, 32'hDEADBEEF);

    // Held hit: no further bus activity
    n_req = 0;
    repeat (5) begin @(negedge clk); n_req += int'(bus_if.bus_req_o); end
    chk("hold_req_pulses", n_req, 0);
    chk("hold_data", if_data, 32'hDEADBEEF);

    // Stray ack while idle is ignored
    drive_edge(); stray_ack = 1;
    drive_edge(); stray_ack = 0;
    @(negedge clk);
    chk("stray_req", bus_if.bus_req_o, 0);
    chk("stray_if_data", if_data, 32'hDEADBEEF);
    chk("stray_me_rdata", me_rdata, 0);

    // Both ports miss: ME first
    drive_edge();
    if_addr = 32'h0; me_ce = 1; me_we = 0; me_addr = 32'h204; me_sel = 4'b0011;
    settle("dual", n_if, n_me, n_req, a0, s0);
    chk("dual_first_addr", a0, 32'h204);
    chk("dual_first_sel", s0, 4'b0011);
    chk("dual_me_stall_cycles", n_me, 4);
    chk("dual_if_stall_cycles", n_if, 8);
    chk("dual_me_data", me_rdata, 32'h22220204);
    chk("dual_if_data", if_data, 32'h11111111);

    // Refetch 0x100, then store to it: fetched copy goes stale
    drive_edge(); if_addr = 32'h100;
    settle("refetch", n_if, n_me, n_req, a0, s0);
    chk("refetch_stall_cycles", n_if, 4);
    drive_edge(); me_we = 1; me_addr = 32'h100; me_sel = 4'hF; me_wdata = 32'h13;
    settle("store", n_if, n_me, n_req, a0, s0);
    chk("store_me_stall_cycles", n_me, 4);
    chk("store_if_restall_cycles", n_if, 4);
    chk("store_me_rdata", me_rdata, 0);
    chk("store_if_new_data", if_data, 32'h13);

    // Reload after an intervening store
    drive_edge(); me_we = 0; me_addr = 32'h204; me_sel = 4'b0011; me_wdata = 0;
    settle("reload", n_if, n_me, n_req, a0, s0);
    chk("reload_me_stall_cycles", n_me, 4);
    chk("reload_me_data", me_rdata, 32'h22220204);

    // Ack in the same cycle the watchdog would fire
    drive_edge(); lat = 4; me_addr = 32'h208; me_sel = 4'hF;
    settle("ack_at_limit", n_if, n_me, n_req, a0, s0);
    chk("limit_me_stall_cycles", n_me, 5);
    chk("limit_me_data", me_rdata, 32'hABCD0208);
    chk("limit_err", err, 0);

    // Never acked: watchdog abort
    drive_edge(); lat = 0; if_addr = 32'h300;
    settle("abort", n_if, n_me, n_req, a0, s0);
    chk("abort_req_cycles", n_req, 4);
    chk("abort_if_stall_cycles", n_if, 5);
    chk("abort_if_data", if_data, 0);
    chk("abort_err", err, 1);
    drive_edge(); lat = 3; if_addr = 32'h100;
    settle("after_abort", n_if, n_me, n_req, a0, s0);
    chk("sticky_err", err, 1);
    chk("after_abort_data", if_data, 32'h13);

    // Reset in the middle of a fetch
    drive_edge(); lat = 0; if_addr = 32'h400;
    @(negedge clk);
    @(negedge clk);
    chk("mid_req_high", bus_if.bus_req_o, 1);
    drive_edge(); rst = 1;
    drive_edge(); rst = 0; lat = 3;
    #1;
    chk("mid_rst_req", bus_if.bus_req_o, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_if_stall", if_stall, 1);
    chk("mid_rst_me_stall", me_stall, 1);
    settle("post_rst", n_if, n_me, n_req, a0, s0);
    chk("post_rst_first_addr", a0, 32'h208);
    chk("post_rst_if_stall_cycles", n_if, 8);
    chk("post_rst_if_data", if_data, 32'h40404040);
    chk("post_rst_me_data", me_rdata, 32'hABCD0208);

    drive_edge(); if_ce = 0; me_ce = 0;
    @(negedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
